// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // States in which the loader is consuming frame bytes.
  function automatic logic is_busy(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into instruction words.
// Ports: clk, rst (sync, active-high), clear (restart at byte 0),
//        byte_valid/byte_data (accepted payload byte),
//        word_c/word_valid_c (complete word, valid in the cycle its last byte arrives).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned HELD_W = (WORD_BYTES - 1) * BYTE_W;

  logic [CNT_W-1:0]  cnt;
  logic [HELD_W-1:0] held;

  // Lower bytes are stored; the final byte goes straight to the output so the
  // write can be registered on the same edge it is accepted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      held <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + CNT_W'(1);
      for (int k = 0; k < int'(WORD_BYTES) - 1; k++) begin
        if (cnt == CNT_W'(k)) held[k*BYTE_W +: BYTE_W] <= byte_data;
      end
    end
  end

  assign word_valid_c = byte_valid && (cnt == CNT_W'(WORD_BYTES - 1));
  assign word_c       = {byte_data, held};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a length/words/XOR-checksum
// byte frame, writes each word to imem and releases core reset on success.
// Ports: clk, rst (sync, active-high), start (begin load from IDLE/DONE/ERR),
//        rx_valid/rx_data/rx_ready (byte stream), imem_we/imem_addr/imem_wdata
//        (memory write port), core_rst, busy, done, err (status).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

  state_t state, state_next;

  logic [BYTE_W-1:0] len_lo;
  logic [LEN_W-1:0]  len;
  logic [IDX_W-1:0]  word_idx;
  logic [BYTE_W-1:0] xor_acc;

  logic              accept_c;
  logic              start_c;
  logic              data_byte_c;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;
  logic [LEN_W-1:0]  len_rx_c;
  logic              last_word_c;
  logic [31:0]       word_addr_c;

  logic rx_ready_d, busy_d, done_d, err_d, core_rst_d;

  assign accept_c    = rx_valid && rx_ready;
  assign start_c     = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign data_byte_c = accept_c && (state == DATA);
  assign len_rx_c    = {rx_data, len_lo};
  assign last_word_c = (32'(word_idx) + 32'd1) == 32'(len);
  assign word_addr_c = BASE_ADDR + 32'(word_idx) * 32'(WORD_BYTES);

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_c),
    .byte_valid   (data_byte_c),
    .byte_data    (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; transitions happen on the edge the qualifying byte lands.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_LO;
      LEN_LO:          if (accept_c) state_next = LEN_HI;
      LEN_HI: begin
        if (accept_c) begin
          if (len_rx_c == '0)                       state_next = CHECK;
          else if (32'(len_rx_c) > 32'(MAX_WORDS))  state_next = ERR;
          else                                      state_next = DATA;
        end
      end
      DATA:  if (word_valid_c && last_word_c) state_next = CHECK;
      CHECK: if (accept_c) state_next = (rx_data == xor_acc) ? DONE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the next state so the registered copies track state.
  always_comb begin
    rx_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    core_rst_d = 1'b1;
    if (is_busy(state_next)) begin
      rx_ready_d = 1'b1;
      busy_d     = 1'b1;
    end
    if (state_next == DONE) begin
      done_d     = 1'b1;
      core_rst_d = 1'b0;
    end
    if (state_next == ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      rx_ready <= rx_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      core_rst <= core_rst_d;
    end
  end

  // Frame bookkeeping and the memory write port; addr/wdata hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      xor_acc    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      imem_we <= word_valid_c;
      if (start_c) begin
        word_idx <= '0;
        xor_acc  <= '0;
      end
      if (accept_c && (state == LEN_LO)) len_lo <= rx_data;
      if (accept_c && (state == LEN_HI)) len    <= len_rx_c;
      if (data_byte_c) xor_acc <= xor_acc ^ rx_data;
      if (word_valid_c) begin
        imem_addr  <= word_addr_c;
        imem_wdata <= word_c;
        word_idx   <= word_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int unsigned MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          wcyc_q[$];
  logic [31:0] words[$];

  int n_chk = 0;
  int n_fail = 0;

  // Observed writes are logged mid-cycle and compared against the scoreboard.
  always @(negedge clk) begin
    if (imem_we) begin
      got_q.push_back({imem_addr, imem_wdata});
      wcyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $error("FAIL rx_ready_timeout: got 0 expected 1 for byte %h", b);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len, input int gap);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
  endtask

  // Sends every word in 'words' and records the write each should produce.
  task automatic send_payload(input int gap);
    logic [31:0] w;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      exp_q.push_back({BASE + 32'(i) * 32'd4, w});
      for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], gap);
    end
  endtask

  function automatic logic [7:0] csum_of();
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    foreach (words[i]) begin
      w = words[i];
      c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return c;
  endfunction

  task automatic check_writes(input string tag);
    logic [63:0] e, g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_addr"}, g[63:32], e[63:32]);
      chk({tag, "_data"}, g[31:0], e[31:0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int c0;
    logic [7:0] cs;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Good two-word frame, with a redundant start while busy
    words = '{32'h0050_0093, 32'h0020_8113};
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    pulse_start();
    chk("start_ignored_busy", 32'(busy), 32'd1);
    wcyc_q.delete();
    send_len(16'd2, 0);
    send_payload(0);
    chk("csum_value", 32'(csum_of()), 32'h71);
    send_byte(csum_of(), 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_core_rst", 32'(core_rst), 32'd0);
    chk("good_err", 32'(err), 32'd0);
    chk("good_rx_ready", 32'(rx_ready), 32'd0);
    chk("good_addr_hold", imem_addr, BASE + 32'd4);
    chk("good_spacing", 32'(wcyc_q[1] - wcyc_q[0]), 32'd4);
    check_writes("good");

    // Same frame with a wrong checksum
    pulse_start();
    chk("restart_core_rst", 32'(core_rst), 32'd1);
    send_len(16'd2, 0);
    send_payload(0);
    send_byte(8'h00, 0);
    chk("badcs_err", 32'(err), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_core_rst", 32'(core_rst), 32'd1);
    check_writes("badcs");

    // Oversized length
    pulse_start();
    send_len(16'(MAXW + 1), 0);
    chk("toolong_err", 32'(err), 32'd1);
    chk("toolong_rx_ready", 32'(rx_ready), 32'd0);
    chk("toolong_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("toolong");

    // Empty frame
    words.delete();
    pulse_start();
    send_len(16'd0, 0);
    send_byte(8'h00, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_core_rst", 32'(core_rst), 32'd0);
    check_writes("empty");

    // Three words with a gap after every byte
    words = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_5A5A};
    pulse_start();
    wcyc_q.delete();
    send_len(16'd3, 1);
    send_payload(1);
    send_byte(csum_of(), 1);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_nwrites", 32'(wcyc_q.size()), 32'd3);
    if (wcyc_q.size() == 3) begin
      chk("gap_spacing0", 32'(wcyc_q[1] - wcyc_q[0]), 32'd8);
      chk("gap_spacing1", 32'(wcyc_q[2] - wcyc_q[1]), 32'd8);
    end
    check_writes("gap");

    // Reset after five payload bytes
    words = '{32'h0050_0093, 32'h0020_8113};
    pulse_start();
    send_len(16'd2, 0);
    exp_q.push_back({BASE, 32'h0050_0093});
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_core_rst_hold", 32'(core_rst), 32'd1);
    check_writes("midrst");

    // Fresh load after the interrupted one
    pulse_start();
    c0 = cyc;
    send_len(16'd2, 0);
    send_payload(0);
    cs = csum_of();
    send_byte(cs, 0);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_core_rst", 32'(core_rst), 32'd0);
    chk("reload_cycles", 32'(cyc - c0), 32'd11);
    check_writes("reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
